// File: rtl/life_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | life_pkg : editor FSM state type, button indices, cell-index width helper  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } editor_state_e;

    localparam int NUM_BUTTONS = 5;
    localparam int BTN_TOGGLE  = 0;
    localparam int BTN_UP      = 1;
    localparam int BTN_DOWN    = 2;
    localparam int BTN_LEFT    = 3;
    localparam int BTN_RIGHT   = 4;

    // Bit width needed to index one of `cells` cells (never less than 1).
    function automatic int cell_idx_width(input int cells);
        return (cells > 2) ? $clog2(cells) : 1;
    endfunction

endpackage : life_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_debouncer : 2-flop sync, level debouncer, rising-edge press pulse,  |
// |                    optional auto-repeat while held (REPEAT_EN)            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic btn_in,
    output logic press_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          rise;
    logic          rep_fire;

    // cnt tracks consecutive samples that disagree with the accepted level;
    // any sample agreeing with it restarts the run.
    assign accept = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept && sync2;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            logic [RW-1:0] rep_cnt;

            assign rep_fire = level && (rep_cnt == RW'(REPEAT_CYCLES - 1));

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    rep_cnt <= '0;
                end else if (!level || rep_fire) begin
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
        end else begin : g_no_repeat
            assign rep_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            press_out <= 1'b0;
        end else begin
            press_out <= rise || rep_fire;
        end
    end

endmodule : button_debouncer
`default_nettype wire

// File: rtl/cell_editor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cell_editor : cursor movement and read-modify-write cell toggle for a      |
// |               line buffer. Define CELL_EDITOR_AUTOREPEAT_EN for repeat.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cell_editor
    import life_pkg::*;
#(
    parameter int LINE_WIDTH      = 8,
    parameter int ADDR_SIZE       = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic                                    btnc_in,
    input  logic                                    btnu_in,
    input  logic                                    btnd_in,
    input  logic                                    btnl_in,
    input  logic                                    btnr_in,
    input  logic                                    edit_en_in,
    output logic [ADDR_SIZE-1:0]                    addr_r_out,
    input  logic [LINE_WIDTH-1:0]                   data_r_in,
    output logic [ADDR_SIZE-1:0]                    addr_w_out,
    output logic [LINE_WIDTH-1:0]                   data_w_out,
    output logic                                    we_out,
    output logic [cell_idx_width(LINE_WIDTH)-1:0]   cursor_x_out,
    output logic [ADDR_SIZE-1:0]                    cursor_y_out,
    output logic                                    busy_out
);

    localparam int XW = cell_idx_width(LINE_WIDTH);

`ifdef CELL_EDITOR_AUTOREPEAT_EN
    localparam bit REPEAT_DIR = 1'b1;
`else
    localparam bit REPEAT_DIR = 1'b0;
`endif

    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] press;

    assign btn_raw[BTN_TOGGLE] = btnc_in;
    assign btn_raw[BTN_UP]     = btnu_in;
    assign btn_raw[BTN_DOWN]   = btnd_in;
    assign btn_raw[BTN_LEFT]   = btnl_in;
    assign btn_raw[BTN_RIGHT]  = btnr_in;

    generate
        for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES),
                .REPEAT_EN       (REPEAT_DIR && (i != BTN_TOGGLE))
            ) u_debouncer (
                .clk_in    (clk_in),
                .rst_n_in  (rst_n_in),
                .btn_in    (btn_raw[i]),
                .press_out (press[i])
            );
        end
    endgenerate

    editor_state_e          state;
    logic [XW-1:0]          cursor_x;
    logic [ADDR_SIZE-1:0]   cursor_y;
    logic [XW-1:0]          lat_x;
    logic [ADDR_SIZE-1:0]   lat_y;

    assign cursor_x_out = cursor_x;
    assign cursor_y_out = cursor_y;
    assign addr_r_out   = (state == ST_READ) ? lat_y : cursor_y;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            cursor_x   <= '0;
            cursor_y   <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            we_out     <= 1'b0;
            busy_out   <= 1'b0;
            addr_w_out <= '0;
            data_w_out <= '0;
        end else begin
            we_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (edit_en_in) begin
                        // Opposing presses on one axis cancel; axes are independent.
                        if (press[BTN_RIGHT] && !press[BTN_LEFT]) begin
                            cursor_x <= cursor_x + XW'(1);
                        end else if (press[BTN_LEFT] && !press[BTN_RIGHT]) begin
                            cursor_x <= cursor_x - XW'(1);
                        end
                        if (press[BTN_DOWN] && !press[BTN_UP]) begin
                            cursor_y <= cursor_y + ADDR_SIZE'(1);
                        end else if (press[BTN_UP] && !press[BTN_DOWN]) begin
                            cursor_y <= cursor_y - ADDR_SIZE'(1);
                        end
                        if (press[BTN_TOGGLE]) begin
                            state    <= ST_READ;
                            lat_x    <= cursor_x;
                            lat_y    <= cursor_y;
                            busy_out <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state      <= ST_WRITE;
                    we_out     <= 1'b1;
                    addr_w_out <= lat_y;
                    data_w_out <= data_r_in ^ (LINE_WIDTH'(1) << lat_x);
                end
                ST_WRITE: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule : cell_editor
`default_nettype wire

// File: tb/tb_cell_editor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cell_editor : randomized and directed stimulus against a behavioural    |
// |                  model of cursor, debounce and read-modify-write rules     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cell_editor;

    localparam int LW  = 8;
    localparam int AS  = 3;
    localparam int NL  = 1 << AS;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btnc = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic          edit_en = 1'b1;
    logic [AS-1:0] addr_r;
    logic [LW-1:0] data_r = '0;
    logic [AS-1:0] addr_w;
    logic [LW-1:0] data_w;
    logic          we;
    logic [2:0]    cursor_x;
    logic [AS-1:0] cursor_y;
    logic          busy;

    cell_editor #(
        .LINE_WIDTH      (LW),
        .ADDR_SIZE       (AS),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (16)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .btnc_in      (btnc),
        .btnu_in      (btnu),
        .btnd_in      (btnd),
        .btnl_in      (btnl),
        .btnr_in      (btnr),
        .edit_en_in   (edit_en),
        .addr_r_out   (addr_r),
        .data_r_in    (data_r),
        .addr_w_out   (addr_w),
        .data_w_out   (data_w),
        .we_out       (we),
        .cursor_x_out (cursor_x),
        .cursor_y_out (cursor_y),
        .busy_out     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    int wr_cnt = 0;
    int wr_addr = 0;
    int wr_data = 0;

    // Model state: cursor, phase (0 idle, 1 read, 2 write), latched cell, write port.
    int m_x, m_y, m_phase, m_lx, m_ly, m_waddr, m_wdata;
    bit m_lvl[5];
    bit m_press[5];
    bit hist[5][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_phase = 0; m_lx = 0; m_ly = 0; m_waddr = 0; m_wdata = 0;
        for (int b = 0; b < 5; b++) begin
            m_lvl[b] = 1'b0;
            m_press[b] = 1'b0;
            hist[b].delete();
            for (int i = 0; i < DEB + 2; i++) hist[b].push_back(1'b0);
        end
    endtask

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_step();
        bit btn[5];
        bit np[5];
        bit all_diff;
        int dx, dy, ox, oy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        btn[0] = btnc; btn[1] = btnu; btn[2] = btnd; btn[3] = btnl; btn[4] = btnr;
        case (m_phase)
            0: if (edit_en) begin
                ox = m_x; oy = m_y;
                dx = int'(m_press[4]) - int'(m_press[3]);
                dy = int'(m_press[2]) - int'(m_press[1]);
                m_x = (m_x + dx + LW) % LW;
                m_y = (m_y + dy + NL) % NL;
                if (m_press[0]) begin
                    m_phase = 1; m_lx = ox; m_ly = oy;
                end
            end
            1: begin
                m_wdata = int'(data_r ^ (8'(1) << m_lx));
                m_waddr = m_ly;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        // A new level is taken once the last DEB synchronised samples (raw
        // delayed two edges) all disagree with the current level.
        for (int b = 0; b < 5; b++) begin
            hist[b].push_back(btn[b]);
            void'(hist[b].pop_front());
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (hist[b][i] == m_lvl[b]) all_diff = 1'b0;
            np[b] = all_diff && !m_lvl[b];
            if (all_diff) m_lvl[b] = !m_lvl[b];
        end
        m_press = np;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cursor_x", 32'(cursor_x), 32'(m_x));
            check("cursor_y", 32'(cursor_y), 32'(m_y));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("we", 32'(we), 32'(m_phase == 2));
            check("addr_r", 32'(addr_r), 32'((m_phase == 1) ? m_ly : m_y));
            check("addr_w", 32'(addr_w), 32'(m_waddr));
            check("data_w", 32'(data_w), 32'(m_wdata));
            if (we === 1'b1) begin
                wr_cnt++;
                wr_addr = int'(addr_w);
                wr_data = int'(data_w);
            end
        end
    end

    task automatic set_btns(input bit [4:0] m);
        btnc = m[0]; btnu = m[1]; btnd = m[2]; btnl = m[3]; btnr = m[4];
    endtask

    task automatic press(input bit [4:0] m);
        set_btns(m);
        repeat (6) cycle();
        set_btns(5'b0);
        repeat (10) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int w0, x0, first;
        bit done;
        bit [4:0] m;
        model_reset();
        rst_n = 1'b0;
        #1;
        check("reset_cursor_x", 32'(cursor_x), 0);
        check("reset_cursor_y", 32'(cursor_y), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_we", 32'(we), 0);
        check("reset_data_w", 32'(data_w), 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        chk_on = 1'b1;
        repeat (3) cycle();

        // Wrap-around from the origin.
        press(5'b01000);
        press(5'b00010);
        check("wrap_x", 32'(cursor_x), 7);
        check("wrap_y", 32'(cursor_y), 7);

        // Left+right cancel while up still applies.
        press(5'b11010);
        check("cancel_x", 32'(cursor_x), 7);
        check("cancel_y", 32'(cursor_y), 6);

        // Right and up together, four times: (7,6) -> (3,2).
        repeat (4) press(5'b10010);
        check("diag_x", 32'(cursor_x), 3);
        check("diag_y", 32'(cursor_y), 2);

        data_r = 8'h00;
        w0 = wr_cnt;
        press(5'b00001);
        check("toggle1_pulses", 32'(wr_cnt - w0), 1);
        check("toggle1_addr", 32'(wr_addr), 2);
        check("toggle1_data", 32'(wr_data), 32'h08);
        data_r = 8'h08;
        w0 = wr_cnt;
        press(5'b00001);
        check("toggle2_pulses", 32'(wr_cnt - w0), 1);
        check("toggle2_data", 32'(wr_data), 32'h00);

        // Bounce 1-0-1 then stable: one move, seven edges after the last change.
        x0 = int'(cursor_x);
        btnr = 1'b1; cycle();
        btnr = 1'b0; cycle();
        btnr = 1'b1;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (first == 0 && int'(cursor_x) != x0) first = n;
        end
        btnr = 1'b0;
        repeat (10) cycle();
        check("bounce_latency", 32'(first), 7);
        check("bounce_x", 32'(cursor_x), 32'((x0 + 1) % LW));

        // Editing disabled: everything ignored.
        edit_en = 1'b0;
        w0 = wr_cnt;
        press(5'b11111);
        check("disabled_x", 32'(cursor_x), 4);
        check("disabled_y", 32'(cursor_y), 2);
        check("disabled_writes", 32'(wr_cnt - w0), 0);
        edit_en = 1'b1;

        // Reset during READ abandons the write.
        btnc = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            cycle();
            if (busy === 1'b1) done = 1'b1;
        end
        check("read_reached", 32'(done), 1);
        btnc = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_read_x", 32'(cursor_x), 0);
        check("rst_read_y", 32'(cursor_y), 0);
        check("rst_read_busy", 32'(busy), 0);
        check("rst_read_we", 32'(we), 0);
        check("rst_read_addr_w", 32'(addr_w), 0);
        check("rst_read_data_w", 32'(data_w), 0);
        check("rst_read_addr_r", 32'(addr_r), 0);
        w0 = wr_cnt;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        check("rst_no_write", 32'(wr_cnt - w0), 0);

        // Randomized phase, checked every cycle against the model.
        for (int it = 0; it < 300; it++) begin
            m = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            edit_en = ($urandom_range(0, 7) != 0);
            set_btns(m);
            repeat ($urandom_range(1, 8)) begin
                data_r = 8'($urandom);
                cycle();
            end
            if ($urandom_range(0, 2) == 0) set_btns(5'b0);
            repeat ($urandom_range(0, 6)) begin
                data_r = 8'($urandom);
                cycle();
            end
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                model_reset();
                cycle();
                rst_n = 1'b1;
            end
        end
        set_btns(5'b0);
        repeat (12) cycle();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cell_editor
`default_nettype wire
